// File: rtl/seg_scan_pkg.sv
// ============================================================================
// Module      : seg_scan_pkg
// Description : Shared types and constants for the seven-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_pkg;

    // Segment pattern {dp,g,f,e,d,c,b,a}, active-low
    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK  = 8'hFF;
    localparam int   MAX_DIGITS = 32;

    typedef logic [MAX_DIGITS-1:0] an_vec_t;

    typedef enum logic [0:0] {
        SLOT_BLANK = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_state_t;

    // All-anodes-off vector for an n-digit display; callers size-cast the result
    function automatic an_vec_t an_off(input int n);
        an_vec_t v;
        v = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_driver_scan_timer.sv
// ============================================================================
// Module      : scan_timer
// Description : Slot/digit counters for the scan driver; emits slot state,
//               current digit index and the end-of-frame wrap strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_timer
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    output slot_state_t                   slot_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_o,
    output logic                          wrap_o
);

    localparam int c_dig_w = $clog2(NUM_DIGITS);
    localparam int c_cnt_w = $clog2(CLK_DIV);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_dig_w-1:0] r_digit;
    logic               w_slot_end;
    logic               w_last_digit;

    assign w_slot_end   = (r_cnt == c_cnt_w'(CLK_DIV - 1));
    assign w_last_digit = (r_digit == c_dig_w'(NUM_DIGITS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_digit <= '0;
        end else if (w_slot_end) begin
            r_cnt   <= '0;
            r_digit <= w_last_digit ? '0 : r_digit + 1'b1;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Guard interval at the start of every slot keeps ghosting off the next digit
    assign slot_o  = (r_cnt < c_cnt_w'(BLANK_CYCLES)) ? SLOT_BLANK : SLOT_DRIVE;
    assign digit_o = r_digit;
    assign wrap_o  = w_slot_end && w_last_digit;

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed seven-segment scan driver with a
//               double-buffered frame store. Optional PWM dimming is enabled
//               by defining DISP_DIM_EN (adds the dim_i port).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_DIGITS*8-1:0]       seg_i,
    input  logic [NUM_DIGITS-1:0]         en_i,
    input  logic                          valid_i,
`ifdef DISP_DIM_EN
    input  logic [3:0]                    dim_i,
`endif
    output logic                          ready_o,
    output logic [NUM_DIGITS-1:0]         an_o,
    output seg_t                          seg_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_o,
    output logic                          frame_o
);

    localparam int                    c_dig_w  = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] c_an_off = NUM_DIGITS'(an_off(NUM_DIGITS));
    localparam logic [NUM_DIGITS-1:0] c_an_one = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    slot_state_t               w_slot;
    logic [c_dig_w-1:0]        w_digit;
    logic                      w_wrap;
    logic                      w_accept;
    seg_t                      w_cur_seg;
    logic                      w_cur_en;
    logic [NUM_DIGITS-1:0]     w_an_sel;
    logic                      w_duty;
    logic                      w_lit;

    logic [NUM_DIGITS*8-1:0]   r_active_seg;
    logic [NUM_DIGITS-1:0]     r_active_en;
    logic [NUM_DIGITS*8-1:0]   r_shadow_seg;
    logic [NUM_DIGITS-1:0]     r_shadow_en;
    logic                      r_pending;
    logic [NUM_DIGITS-1:0]     r_an;
    seg_t                      r_seg;

    scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .slot_o  (w_slot),
        .digit_o (w_digit),
        .wrap_o  (w_wrap)
    );

    assign w_accept = valid_i && !r_pending;

    // Accept and swap are exclusive: accept needs pending low, swap needs it high,
    // so a frame accepted on a wrap cycle waits for the following wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_active_seg <= {NUM_DIGITS{SEG_BLANK}};
            r_active_en  <= '0;
            r_shadow_seg <= {NUM_DIGITS{SEG_BLANK}};
            r_shadow_en  <= '0;
            r_pending    <= 1'b0;
        end else if (w_accept) begin
            r_shadow_seg <= seg_i;
            r_shadow_en  <= en_i;
            r_pending    <= 1'b1;
        end else if (w_wrap && r_pending) begin
            r_active_seg <= r_shadow_seg;
            r_active_en  <= r_shadow_en;
            r_pending    <= 1'b0;
        end
    end

    assign w_cur_seg = r_active_seg[{w_digit, 3'b000} +: 8];
    assign w_cur_en  = r_active_en[w_digit];
    assign w_an_sel  = ~(c_an_one << w_digit);

`ifdef DISP_DIM_EN
    logic [3:0] r_pwm;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pwm <= 4'd0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
        end
    end

    assign w_duty = (r_pwm <= dim_i);
`else
    assign w_duty = 1'b1;
`endif

    assign w_lit = (w_slot == SLOT_DRIVE) && w_cur_en && w_duty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_an  <= c_an_off;
            r_seg <= SEG_BLANK;
        end else if (w_lit) begin
            r_an  <= w_an_sel;
            r_seg <= w_cur_seg;
        end else begin
            r_an  <= c_an_off;
            r_seg <= SEG_BLANK;
        end
    end

    assign ready_o = !r_pending;
    assign an_o    = r_an;
    assign seg_o   = r_seg;
    assign digit_o = w_digit;
    assign frame_o = w_wrap;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Scoreboard bench for seg_scan_driver (4 digits, 8-clock slots,
//               2-clock blanking) against a time-indexed frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int CD = 8;
    localparam int BC = 2;
    localparam int P  = ND * CD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] seg_in = '0;
    logic [3:0]  en_in = '0;
    logic        valid = 1'b0;
    logic        ready;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  digit;
    logic        frame;
`ifdef DISP_DIM_EN
    logic [3:0]  dim = 4'hF;
`endif

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .CLK_DIV      (CD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .seg_i   (seg_in),
        .en_i    (en_in),
        .valid_i (valid),
`ifdef DISP_DIM_EN
        .dim_i   (dim),
`endif
        .ready_o (ready),
        .an_o    (an),
        .seg_o   (seg),
        .digit_o (digit),
        .frame_o (frame)
    );

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic [1:0] digit;
        logic       frame;
        logic       ready;
    } exp_t;

    typedef struct {
        logic [31:0] seg;
        logic [3:0]  en;
        int          acc;
        int          app;
    } frame_t;

    exp_t   exp_q[$];
    frame_t frames[$];
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // A frame accepted at edge a becomes visible after the first wrap edge strictly later than a
    function automatic int apply_edge(input int a);
        int w;
        w = (a / P) * P + P - 1;
        if (w <= a) w += P;
        return w;
    endfunction

    function automatic bit model_pending(input int k);
        foreach (frames[i])
            if (frames[i].acc < k && k <= frames[i].app) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t expect_at(input int k);
        exp_t        e;
        logic [31:0] s;
        logic [3:0]  m;
        int          d;
        s = '1;
        m = '0;
        foreach (frames[i])
            if (frames[i].app < k) begin
                s = frames[i].seg;
                m = frames[i].en;
            end
        d = (k / CD) % ND;
        if ((k % CD) >= BC && m[d]) begin
            e.an  = ~(4'b0001 << d);
            e.seg = s[d*8 +: 8];
        end else begin
            e.an  = 4'hF;
            e.seg = 8'hFF;
        end
        e.digit = 2'(((k + 1) / CD) % ND);
        e.frame = (((k + 1) % P) == P - 1);
        e.ready = !model_pending(k + 1);
        return e;
    endfunction

    exp_t me;

    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("an",    32'(an),    32'(me.an));
            chk("seg",   32'(seg),   32'(me.seg));
            chk("digit", 32'(digit), 32'(me.digit));
            chk("frame", 32'(frame), 32'(me.frame));
            chk("ready", 32'(ready), 32'(me.ready));
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"},    32'(an),    32'hF);
        chk({tag, "_seg"},   32'(seg),   32'hFF);
        chk({tag, "_ready"}, 32'(ready), 32'h1);
        chk({tag, "_digit"}, 32'(digit), 32'h0);
        chk({tag, "_frame"}, 32'(frame), 32'h0);
    endtask

    initial begin
        int  k;
        int  quiet;
        int  dir_idx;
        bit  pend;
        bit  did_reset;

        k = 0;
        quiet = 0;
        dir_idx = 0;
        did_reset = 1'b0;

        // Reset asserted between edges must blank outputs with no clock
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int n = 0; n < 1400; n++) begin
            @(negedge clk);
            pend   = model_pending(k);
            valid  = 1'b0;
            seg_in = $urandom;
            en_in  = 4'($urandom_range(0, 15));
            if (pend) begin
                valid = 1'($urandom_range(0, 1));
            end else if (quiet > 0) begin
                quiet--;
            end else if ($urandom_range(0, 3) == 0) begin
                valid = 1'b1;
                if (dir_idx == 0) begin
                    seg_in = 32'h99B0A4C0;
                    en_in  = 4'hF;
                end else if (dir_idx == 1) begin
                    en_in  = 4'b0101;
                end
                dir_idx++;
            end
            if (valid && !pend)
                frames.push_back('{seg_in, en_in, k, apply_edge(k)});
            exp_q.push_back(expect_at(k));

            if (!did_reset && k >= 200 && model_pending(k + 1) &&
                ((k + 1) % CD) >= BC && (((k + 1) / CD) % ND) == 2) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1 check_reset_outputs("rst_mid");
                repeat (2) @(posedge clk);
                #2 rst_n = 1'b1;
                did_reset = 1'b1;
                frames.delete();
                k = 0;
                quiet = 40;
                continue;
            end
            k++;
        end

        @(posedge clk);
        #3;
        chk("reset_window_reached", 32'(did_reset), 32'h1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
